// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
// The master drives the requests and the slave (the FIFO) drives the status.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              w_en;
  logic [DATA_W-1:0] inp;
  logic              r_en;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              r_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output w_en, inp, r_en, clr_err,
    input  data_out, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_en, inp, r_en, clr_err,
    output data_out, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, and a registered or fall-through read port.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = (2 ** ADDR_W) - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0]  r_ptr_q, r_ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              r_valid_q, r_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              full_c;
  logic              empty_c;
  logic              wr_acc_c;
  logic              rd_acc_c;
  logic [PTR_W-1:0]  count_c;
  logic [DATA_W-1:0] head_c;

  // Status decoded purely from registered pointers (extra MSB distinguishes full from empty)
  assign full_c   = (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]) &&
                    (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]);
  assign empty_c  = (w_ptr_q == r_ptr_q);
  assign count_c  = w_ptr_q - r_ptr_q;
  assign wr_acc_c = bus.w_en & ~full_c;
  assign rd_acc_c = bus.r_en & ~empty_c;
  assign head_c   = mem_q[r_ptr_q[ADDR_W-1:0]];

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    rdata_d   = rdata_q;
    r_valid_d = 1'b0;
    ovf_d     = ovf_q;
    udf_d     = udf_q;

    if (wr_acc_c) begin
      w_ptr_d = w_ptr_q + PTR_W'(1);
    end
    if (rd_acc_c) begin
      r_ptr_d   = r_ptr_q + PTR_W'(1);
      rdata_d   = head_c;
      r_valid_d = 1'b1;
    end

    // Error set takes priority over a same-cycle clear
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.w_en && full_c) begin
      ovf_d = 1'b1;
    end
    if (bus.r_en && empty_c) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      rdata_q   <= '0;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      rdata_q   <= rdata_d;
      r_valid_q <= r_valid_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_c) begin
      mem_q[w_ptr_q[ADDR_W-1:0]] <= bus.inp;
    end
  end

  assign bus.data_out     = FWFT ? head_c : rdata_q;
  assign bus.r_valid      = FWFT ? ~empty_c : r_valid_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (32'(count_c) >= AF_LEVEL);
  assign bus.almost_empty = (32'(count_c) <= AE_LEVEL);
  assign bus.count        = count_c;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
